// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per
//            clock, with parallel result, final borrow-out and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic w_accept;
    logic w_shift;
    logic w_last;
    logic w_a0;
    logic w_b0;
    logic w_d;
    logic w_bout;

    // A new request is taken in IDLE and also in DONE for back-to-back use.
    assign w_accept = start && ((state_q == c_IDLE) || (state_q == c_DONE));
    assign w_shift  = (state_q == c_SHIFT);
    assign w_last   = w_shift && (cnt_q == c_LAST);

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_a0   = areg_q[0];
    assign w_b0   = breg_q[0];
    assign w_d    = w_a0 ^ w_b0 ^ bin_q;
    assign w_bout = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & bin_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start) state_d = c_SHIFT;
            c_SHIFT: if (w_last) state_d = c_DONE;
            c_DONE:  state_d = start ? c_SHIFT : c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            c_SHIFT: busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        areg_d   = areg_q;
        breg_d   = breg_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (w_accept) begin
            areg_d = a;
            breg_d = b;
            res_d  = '0;
            bin_d  = 1'b0;
            cnt_d  = '0;
        end else if (w_shift) begin
            areg_d = areg_q >> 1;
            breg_d = breg_q >> 1;
            res_d  = {w_d, res_q[WIDTH-1:1]};
            bin_d  = w_bout;
            cnt_d  = cnt_q + CW'(1);
            // Results are published only on the completion edge and held after.
            if (w_last) begin
                diff_d   = {w_d, res_q[WIDTH-1:1]};
                borrow_d = w_bout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            areg_q   <= '0;
            breg_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Self-checking bench for serial_sub (WIDTH=8 and WIDTH=4 instances)
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] diff8;
    logic       borrow8, busy8, done8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic [3:0] diff4;
    logic       borrow4, busy4, done4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       b;
    } exp4_t;
    exp4_t sb4[$];

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .diff   (diff8),
        .borrow (borrow8),
        .busy   (busy8),
        .done   (done8)
    );

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .diff   (diff4),
        .borrow (borrow4),
        .busy   (busy4),
        .done   (done4)
    );

    // Drive one request into the 8-bit instance and return at the negedge
    // where done is seen (or when the cycle budget runs out). Operands are
    // scrambled after acceptance to show they are not re-sampled.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           output int cyc, output int busy_lo);
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        cyc     = 1;
        busy_lo = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 !== 1'b1) busy_lo++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b1; start4 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({diff8, borrow8, busy8, done8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got diff=%h borrow=%b busy=%b done=%b, want all 0",
                     diff8, borrow8, busy8, done8);
        end
        n_checks++;
        if ({diff4, borrow4, busy4, done4} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset4: got diff=%h borrow=%b busy=%b done=%b, want all 0",
                     diff4, borrow4, busy4, done4);
        end
        start8 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, blo;
        run_op8(8'd100, 8'd37, cyc, blo);
        n_checks++;
        if (cyc != 9 || blo != 0) begin
            n_fail++;
            $display("FAIL basic_timing: got done at cycle %0d busy-low %0d, want 9 and 0", cyc, blo);
        end
        n_checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || diff8 !== 8'h3F || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got done=%b busy=%b diff=%h borrow=%b, want 1 0 3f 0",
                     done8, busy8, diff8, borrow8);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h3F || borrow8 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_hold: got done=%b busy=%b diff=%h borrow=%b, want 0 0 3f 0",
                         done8, busy8, diff8, borrow8);
            end
        end
    endtask

    task automatic test_underflow;
        logic [7:0] av[$] = '{8'd5, 8'd0, 8'hFF};
        logic [7:0] bv[$] = '{8'd10, 8'd1, 8'hFF};
        int cyc, blo;
        logic [7:0] ed;
        logic       eb;
        for (int i = 0; i < 20; i++) begin
            av.push_back(8'($urandom));
            bv.push_back(8'($urandom));
        end
        for (int i = 0; i < av.size(); i++) begin
            ed = 8'((int'(av[i]) - int'(bv[i]) + 256) % 256);
            eb = (av[i] < bv[i]);
            run_op8(av[i], bv[i], cyc, blo);
            n_checks++;
            if (cyc != 9 || done8 !== 1'b1 || diff8 !== ed || borrow8 !== eb) begin
                n_fail++;
                $display("FAIL sub %0d-%0d: got cyc=%0d done=%b diff=%h borrow=%b, want cyc=9 done=1 diff=%h borrow=%b",
                         av[i], bv[i], cyc, done8, diff8, borrow8, ed, eb);
            end
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0) begin
                n_fail++;
                $display("FAIL sub_pulse: got done=%b one cycle later, want 0", done8);
            end
        end
    endtask

    task automatic test_start_busy;
        int pulses = 0;
        int at = -1;
        logic [7:0] dseen = '0;
        logic       bseen = 1'b0;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                pulses++;
                at = cyc;
                dseen = diff8;
                bseen = borrow8;
            end
            if (cyc == 3) begin
                start8 = 1'b1; a8 = 8'd200; b8 = 8'd1;
            end else begin
                start8 = 1'b0;
            end
        end
        n_checks++;
        if (pulses != 1 || at != 9) begin
            n_fail++;
            $display("FAIL start_busy_pulses: got %0d pulses (last at %0d), want 1 at 9", pulses, at);
        end
        n_checks++;
        if (dseen !== 8'd5 || bseen !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_result: got diff=%0d borrow=%b, want 5 0", dseen, bseen);
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int bad_pos = 0;
        int bad_val = 0;
        bit seen = 0;
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        for (int cyc = 1; cyc <= 28; cyc++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                pulses++;
                seen = 1;
                if (cyc % 9 != 0) bad_pos++;
            end
            if (seen && (diff8 !== 8'd30 || borrow8 !== 1'b0)) bad_val++;
        end
        start8 = 1'b0;
        n_checks++;
        if (pulses != 3 || bad_pos != 0) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d pulses, %0d off-period, want 3 and 0", pulses, bad_pos);
        end
        n_checks++;
        if (bad_val != 0) begin
            n_fail++;
            $display("FAIL b2b_stable: got %0d cycles with diff!=30, want 0", bad_val);
        end
        for (int i = 0; i < 15 && busy8 === 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        int cyc, blo;
        @(negedge clk);
        a8 = 8'($urandom_range(128, 255)); b8 = 8'($urandom_range(1, 127)); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'd0 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0",
                     busy8, done8, diff8, borrow8);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles after abort, want 0", pulses);
        end
        run_op8(8'd7, 8'd7, cyc, blo);
        n_checks++;
        if (cyc != 9 || done8 !== 1'b1 || diff8 !== 8'd0 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_resume: got cyc=%0d done=%b diff=%h borrow=%b, want 9 1 00 0",
                     cyc, done8, diff8, borrow8);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive4;
        exp4_t e;
        int cyc;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                @(negedge clk);
                a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
                e.d = 4'((ia - ib) & 15);
                e.b = (ia < ib);
                sb4.push_back(e);
                @(negedge clk);
                start4 = 1'b0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                cyc = 1;
                while (done4 !== 1'b1 && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                n_checks++;
                if (done4 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ex4_timeout %0d-%0d: got no done in %0d cycles, want done", ia, ib, cyc);
                end else begin
                    e = sb4.pop_front();
                    if (diff4 !== e.d || borrow4 !== e.b || cyc != 5) begin
                        n_fail++;
                        $display("FAIL ex4 %0d-%0d: got diff=%h borrow=%b cyc=%0d, want diff=%h borrow=%b cyc=5",
                                 ia, ib, diff4, borrow4, cyc, e.d, e.b);
                    end
                end
            end
        end
        n_checks++;
        if (sb4.size() != 0) begin
            n_fail++;
            $display("FAIL ex4_scoreboard: got %0d results outstanding, want 0", sb4.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
